counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Programmable sequencer and controller for a WIDTH-bit count register: start/stop/pause control, up or down direction, one-shot or auto-reload mode, and a clock prescaler. It turns the free-running ripple/async counters into a timer-style resource that higher-level control can start, pause and query. It sits between control logic (FSMs, testbenches, future bus slave) and anything consuming count/terminal events.

Parameters:
WIDTH, 4, bit width of the count register and limit.
PRESCALE, 1, clock cycles per count step (>=1); 1 = step every cycle while running.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  sampled each edge; (re)starts a sequence, latches mode/dir/limit.
stop  input  1  sampled each edge; abort to IDLE; priority over start and pause.
pause  input  1  level; freezes counting while high in RUN.
mode  input  1  0 = one-shot, 1 = auto-reload.
dir  input  1  0 = up (0 -> limit), 1 = down (limit -> 0).
limit  input  WIDTH  terminal (up) or load (down) value.
counter  output  WIDTH  current count, registered.
busy  output  1  high in RUN or PAUSED.
done  output  1  one-cycle pulse when terminal value is reached.
wrap_cnt  output  8  completed periods in auto-reload; saturates at 255.
state  output  2  IDLE=0, RUN=1, PAUSED=2, DONE=3.

Behaviour:
- Reset (async, immediate): counter=0, state=IDLE, busy=0, done=0, wrap_cnt=0, prescaler=0, latched mode/dir/limit=0.
- Priority per edge: stop > start > pause > step.
- stop: any state -> IDLE; counter=0, prescaler=0, done=0; wrap_cnt holds.
- start (any state, stop low): latch mode/dir/limit; counter = 0 (up) or limit (down); prescaler=0; wrap_cnt=0; state=RUN. Restarts mid-run or from PAUSED/DONE. Input changes after start are ignored until the next start.
- Step: in RUN with pause low, the prescaler counts 0..PRESCALE-1; a step occurs on the edge where prescaler==PRESCALE-1, then the prescaler wraps to 0. First step is PRESCALE edges after the start edge.
- Terminal value T = limit (up) or 0 (down). Start value S = 0 (up) or limit (down).
- Step with counter != T: counter +/-1. If the new value == T: done=1 for that cycle. In one-shot mode state -> DONE and counter holds T.
- Step with counter == T (auto-reload only): counter = S, wrap_cnt+1 (saturating at 255). Period = limit+1 steps.
- limit==0 (S==T): first step asserts done. One-shot -> DONE. Auto-reload: done on every step, counter stays 0, wrap_cnt increments every step.
- pause high in RUN: state -> PAUSED on that edge; no step, prescaler holds. PAUSED with pause low -> RUN; the prescaler resumes from its held value. pause is ignored in IDLE and DONE.
- DONE: counter holds T, busy=0; leaves only on start, stop, or reset.
- done is never high for two consecutive cycles except in the limit==0 auto-reload case with PRESCALE=1.
- No wrap past T in either direction; counter never leaves [0, limit].

Test Plan:
- Reset, then start with mode=0, dir=0, limit=5, PRESCALE=1 -> counter 0,1,2,3,4,5 on consecutive edges; done high only in the cycle counter becomes 5; state=3, busy=0, counter holds 5.
- start with mode=1, dir=1, limit=3 -> counter 3,2,1,0,3,2,1,0,...; done pulses at each 0; wrap_cnt increments at each 0->3 reload; run 300 periods -> wrap_cnt stays 255.
- Up-count limit=9: pause high for 4 cycles at counter=4 -> state=2, counter holds 4; release -> resumes 5..9; done once at 9.
- Mid-run at counter=6: assert start and stop together -> state=0, counter=0, no done. Then start alone with limit=2 -> fresh 0,1,2 sequence.
- PRESCALE=3, limit=2, up, one-shot -> counter changes every 3rd edge; done exactly 6 edges after start.
- Assert reset asynchronously between clock edges during RUN -> all outputs return to reset values immediately, without waiting for a clock edge. limit=0 one-shot start -> done on the first step, counter stays 0.

Source files
------------

// File: rtl/counter_sequencer.sv
// Timer-style sequencer around a WIDTH-bit count register: start/stop/pause,
// up/down direction, one-shot or auto-reload, with a clock prescaler.
module counter_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wrap_cnt,
  output logic [1:0]       state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           st, st_nxt;
  logic [WIDTH-1:0] cnt_nxt, lim_l, lim_nxt, term, base, stepped;
  logic [PW-1:0]    pre, pre_nxt;
  logic [7:0]       wrap_nxt;
  logic             done_nxt, mode_l, mode_nxt, dir_l, dir_nxt;

  assign term    = dir_l ? '0 : lim_l;
  assign base    = dir_l ? lim_l : '0;
  assign stepped = dir_l ? counter - WIDTH'(1) : counter + WIDTH'(1);
  assign state   = st;
  assign busy    = (st == S_RUN) || (st == S_PAUSED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st       <= S_IDLE;
      counter  <= '0;
      pre      <= '0;
      wrap_cnt <= '0;
      done     <= 1'b0;
      mode_l   <= 1'b0;
      dir_l    <= 1'b0;
      lim_l    <= '0;
    end else begin
      st       <= st_nxt;
      counter  <= cnt_nxt;
      pre      <= pre_nxt;
      wrap_cnt <= wrap_nxt;
      done     <= done_nxt;
      mode_l   <= mode_nxt;
      dir_l    <= dir_nxt;
      lim_l    <= lim_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    cnt_nxt  = counter;
    pre_nxt  = pre;
    wrap_nxt = wrap_cnt;
    done_nxt = 1'b0;
    mode_nxt = mode_l;
    dir_nxt  = dir_l;
    lim_nxt  = lim_l;

    if (stop) begin
      st_nxt  = S_IDLE;
      cnt_nxt = '0;
      pre_nxt = '0;
    end else if (start) begin
      mode_nxt = mode;
      dir_nxt  = dir;
      lim_nxt  = limit;
      cnt_nxt  = dir ? limit : '0;
      pre_nxt  = '0;
      wrap_nxt = '0;
      st_nxt   = S_RUN;
    end else begin
      case (st)
        S_RUN: begin
          if (pause) begin
            st_nxt = S_PAUSED;
          end else if (pre == PRE_LAST) begin
            pre_nxt = '0;
            if (counter != term) begin
              cnt_nxt = stepped;
              if (stepped == term) begin
                done_nxt = 1'b1;
                if (!mode_l) st_nxt = S_DONE;
              end
            end else if (mode_l) begin
              // Reload; when limit==0 the start value is itself terminal.
              cnt_nxt  = base;
              wrap_nxt = (wrap_cnt == 8'hFF) ? wrap_cnt : wrap_cnt + 8'd1;
              done_nxt = (base == term);
            end else begin
              done_nxt = 1'b1;
              st_nxt   = S_DONE;
            end
          end else begin
            pre_nxt = pre + PW'(1);
          end
        end
        S_PAUSED: if (!pause) st_nxt = S_RUN;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed stimulus pushes expected
// outputs; a negedge monitor pops and compares.
module tb_counter_sequencer;

  logic       clock, reset, start, stop, pause, mode, dir;
  logic [3:0] limit;
  logic [3:0] c0, c1;
  logic       b0, b1, d0, d1;
  logic [7:0] w0, w1;
  logic [1:0] s0, s1;

  counter_sequencer #(.WIDTH(4), .PRESCALE(1)) dut0 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .dir(dir), .limit(limit), .counter(c0), .busy(b0),
    .done(d0), .wrap_cnt(w0), .state(s0)
  );

  counter_sequencer #(.WIDTH(4), .PRESCALE(3)) dut1 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .dir(dir), .limit(limit), .counter(c1), .busy(b1),
    .done(d1), .wrap_cnt(w1), .state(s1)
  );

  typedef struct {
    bit         u;
    logic [3:0] c;
    logic [1:0] s;
    logic       b;
    logic       d;
    logic [7:0] w;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push(input bit u, input int c, input int s, input bit b,
                      input bit d, input int w, input string nm);
    exp_t e;
    e.u = u; e.c = 4'(c); e.s = 2'(s); e.b = b; e.d = d; e.w = 8'(w); e.nm = nm;
    q.push_back(e);
  endtask

  // Let one clock edge happen with the current inputs, then expect the result.
  task automatic ex(input bit u, input int c, input int s, input bit b,
                    input bit d, input int w, input string nm);
    @(posedge clock);
    #1;
    push(u, c, s, b, d, w, nm);
  endtask

  always @(negedge clock) begin : monitor
    exp_t       e;
    logic [3:0] ac;
    logic [1:0] as;
    logic       ab, ad;
    logic [7:0] aw;
    while (q.size() > 0) begin
      e  = q.pop_front();
      ac = e.u ? c1 : c0;
      as = e.u ? s1 : s0;
      ab = e.u ? b1 : b0;
      ad = e.u ? d1 : d0;
      aw = e.u ? w1 : w0;
      total++;
      if (ac !== e.c || as !== e.s || ab !== e.b || ad !== e.d || aw !== e.w) begin
        bad++;
        $display("FAIL %s: got cnt=%0d st=%0d busy=%0d done=%0d wrap=%0d, want cnt=%0d st=%0d busy=%0d done=%0d wrap=%0d",
                 e.nm, ac, as, ab, ad, aw, e.c, e.s, e.b, e.d, e.w);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int ec, ew;
    bit ed;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mode = 1'b0; dir = 1'b0; limit = 4'd0;
    @(posedge clock);
    #1;
    push(0, 0, 0, 0, 0, 0, "reset");
    reset = 1'b0;

    // One-shot up to 5
    start = 1'b1; mode = 1'b0; dir = 1'b0; limit = 4'd5;
    ex(0, 0, 1, 1, 0, 0, "os_start");
    start = 1'b0;
    for (int i = 1; i <= 4; i++) ex(0, i, 1, 1, 0, 0, "os_up");
    ex(0, 5, 3, 0, 1, 0, "os_term");
    ex(0, 5, 3, 0, 0, 0, "os_hold");

    // Auto-reload down from 3, then saturate wrap_cnt
    start = 1'b1; mode = 1'b1; dir = 1'b1; limit = 4'd3;
    ex(0, 3, 1, 1, 0, 0, "ar_start");
    start = 1'b0;
    ex(0, 2, 1, 1, 0, 0, "ar_dn");
    ex(0, 1, 1, 1, 0, 0, "ar_dn");
    ex(0, 0, 1, 1, 1, 0, "ar_zero");
    ex(0, 3, 1, 1, 0, 1, "ar_reload");
    ex(0, 2, 1, 1, 0, 1, "ar_dn");
    ex(0, 1, 1, 1, 0, 1, "ar_dn");
    ex(0, 0, 1, 1, 1, 1, "ar_zero");
    ex(0, 3, 1, 1, 0, 2, "ar_reload");
    ec = 3; ew = 2;
    for (int i = 0; i < 1200; i++) begin
      if (ec == 0) begin
        ec = 3; ew = (ew < 255) ? ew + 1 : 255; ed = 1'b0;
      end else begin
        ec = ec - 1; ed = (ec == 0);
      end
      ex(0, ec, 1, 1, ed, ew, "ar_loop");
    end
    ex(0, 2, 1, 1, 0, 255, "ar_sat");

    // Pause at 4 for four edges, then resume to 9
    start = 1'b1; mode = 1'b0; dir = 1'b0; limit = 4'd9;
    ex(0, 0, 1, 1, 0, 0, "p_start");
    start = 1'b0;
    for (int i = 1; i <= 4; i++) ex(0, i, 1, 1, 0, 0, "p_up");
    pause = 1'b1;
    for (int i = 0; i < 4; i++) ex(0, 4, 2, 1, 0, 0, "p_hold");
    pause = 1'b0;
    ex(0, 4, 1, 1, 0, 0, "p_resume");
    for (int i = 5; i <= 8; i++) ex(0, i, 1, 1, 0, 0, "p_up2");
    ex(0, 9, 3, 0, 1, 0, "p_term");
    ex(0, 9, 3, 0, 0, 0, "p_done_hold");

    // stop beats start mid-run, then a fresh short sequence
    start = 1'b1; mode = 1'b1; dir = 1'b0; limit = 4'd9;
    ex(0, 0, 1, 1, 0, 0, "sp_start");
    start = 1'b0;
    for (int i = 1; i <= 6; i++) ex(0, i, 1, 1, 0, 0, "sp_up");
    start = 1'b1; stop = 1'b1;
    ex(0, 0, 0, 0, 0, 0, "stop_prio");
    stop = 1'b0; mode = 1'b0; limit = 4'd2;
    ex(0, 0, 1, 1, 0, 0, "restart");
    start = 1'b0;
    ex(0, 1, 1, 1, 0, 0, "restart_up");
    ex(0, 2, 3, 0, 1, 0, "restart_term");

    // Prescaler of 3 on the second instance
    start = 1'b1; mode = 1'b0; dir = 1'b0; limit = 4'd2;
    ex(1, 0, 1, 1, 0, 0, "ps_start");
    start = 1'b0;
    ex(1, 0, 1, 1, 0, 0, "ps_wait");
    ex(1, 0, 1, 1, 0, 0, "ps_wait");
    ex(1, 1, 1, 1, 0, 0, "ps_step1");
    ex(1, 1, 1, 1, 0, 0, "ps_wait");
    ex(1, 1, 1, 1, 0, 0, "ps_wait");
    ex(1, 2, 3, 0, 1, 0, "ps_term");

    // Asynchronous reset between edges during RUN
    start = 1'b1; limit = 4'd9;
    ex(0, 0, 1, 1, 0, 0, "ar2_start");
    start = 1'b0;
    ex(0, 1, 1, 1, 0, 0, "ar2_up");
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (c0 !== 4'd0) begin
      bad++;
      $display("FAIL async_reset_cnt: got %0d", c0);
    end
    total++;
    if (s0 !== 2'd0) begin
      bad++;
      $display("FAIL async_reset_state: got %0d", s0);
    end
    total++;
    if (b0 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_busy: got %0d", b0);
    end
    push(0, 0, 0, 0, 0, 0, "async_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // limit 0, one-shot
    start = 1'b1; mode = 1'b0; dir = 1'b0; limit = 4'd0;
    ex(0, 0, 1, 1, 0, 0, "l0_start");
    start = 1'b0;
    ex(0, 0, 3, 0, 1, 0, "l0_done");
    ex(0, 0, 3, 0, 0, 0, "l0_hold");

    // limit 0, auto-reload: done every step; stop keeps wrap_cnt
    start = 1'b1; mode = 1'b1;
    ex(0, 0, 1, 1, 0, 0, "l0ar_start");
    start = 1'b0;
    ex(0, 0, 1, 1, 1, 1, "l0ar_step");
    ex(0, 0, 1, 1, 1, 2, "l0ar_step");
    ex(0, 0, 1, 1, 1, 3, "l0ar_step");
    stop = 1'b1;
    ex(0, 0, 0, 0, 0, 3, "stop_wrap_hold");
    stop = 1'b0;
    pause = 1'b1;
    ex(0, 0, 0, 0, 0, 3, "idle_pause_ignored");
    pause = 1'b0;

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad != 0 || total < 12) begin
      $display("FAIL: %0d mismatches", bad);
      $fatal(1);
    end
    $display("PASS");
    $finish;
  end

endmodule
